ball_collision_det: RTL and testbench

- Upstream stage of the ball x-position mover; generates the `collision_det` level that the mover samples once per movement tick.
- Compares ball centre (x_pos, y_pos) against left/right paddle hit zones.
- Holds collision_det until the mover reacts (x_pos changes), then enforces a lockout so one bounce cannot double-trigger.
- Also emits one-cycle hit and miss (wall-reached) pulses for scoring logic.

---
 rtl/ball_collision_det.sv | 226 ++++++++++++++++++++++
 tb/tb_ball_collision_det.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_collision_det.sv
// -----------------------------------------------------------------------------
// ball_collision_det
//
// Upstream stage of the ball x-position mover. Detects when the ball centre
// enters either paddle's hit zone and raises collision_det. The level is held
// until the mover reacts by changing x_pos, or until HOLD_MAX cycles elapse.
// After release, a lockout ignores the zones until LOCKOUT_STEPS further x_pos
// changes have been seen, so one bounce cannot trigger twice. Independent
// wall-reached detectors emit one-cycle miss pulses for the scoring logic.
//
// Pipeline: stage 1 registers the zone compares; stage 2 is the FSM with
// registered outputs. Input change to collision_det rise is 2 cycles.
// Miss pulses have 1 cycle latency. No input reaches an output
// combinationally.
//
// Ports:
//   pclk          in   1   pixel clock, all logic on the rising edge
//   reset         in   1   synchronous, active-high
//   x_pos         in  12   ball centre x (from the x mover)
//   y_pos         in  12   ball centre y
//   paddle_l_y    in  12   left paddle top edge
//   paddle_r_y    in  12   right paddle top edge
//   collision_det out  1   high while a hit is pending for the mover
//   hit_left      out  1   one-cycle pulse on entry to HIT from the left zone
//   hit_right     out  1   one-cycle pulse on entry to HIT from the right zone
//   miss_left     out  1   one-cycle pulse when the ball reaches the left wall
//   miss_right    out  1   one-cycle pulse when the ball reaches the right wall
// -----------------------------------------------------------------------------
module ball_collision_det #(
    parameter int BALL_R        = 10,
    parameter int PADDLE_L_X    = 30,
    parameter int PADDLE_R_X    = 993,
    parameter int PADDLE_H      = 100,
    parameter int SCREEN_MAX_X  = 1023,
    parameter int LOCKOUT_STEPS = 4,
    parameter int HOLD_MAX      = 1_000_000
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic [11:0] x_pos,
    input  logic [11:0] y_pos,
    input  logic [11:0] paddle_l_y,
    input  logic [11:0] paddle_r_y,
    output logic        collision_det,
    output logic        hit_left,
    output logic        hit_right,
    output logic        miss_left,
    output logic        miss_right
);

    // Counter widths; never allowed to collapse to zero bits.
    localparam int HOLD_W = (HOLD_MAX < 2)      ? 1 : $clog2(HOLD_MAX + 1);
    localparam int LOCK_W = (LOCKOUT_STEPS < 1) ? 1 : $clog2(LOCKOUT_STEPS + 1);

    // All geometry is evaluated in 13 bits so the sums never wrap.
    localparam logic [12:0] RADIUS  = 13'(BALL_R);
    localparam logic [12:0] L_EDGE  = 13'(PADDLE_L_X + BALL_R);
    localparam logic [12:0] R_EDGE  = 13'(PADDLE_R_X);
    localparam logic [12:0] Y_SPAN  = 13'(PADDLE_H + BALL_R);
    localparam logic [12:0] WALL_R  = 13'(SCREEN_MAX_X);
    localparam logic [11:0] WALL_L  = 12'(BALL_R);

    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_MAX - 1);
    localparam logic [LOCK_W-1:0] LOCK_START = LOCK_W'(LOCKOUT_STEPS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HIT     = 2'd1,
        LOCKOUT = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Stage 1: zone compares and wall detection (index 0 = left, 1 = right)
    // -------------------------------------------------------------------------
    logic [12:0] x13;
    logic [12:0] y13;
    logic [11:0] pad_y [2];
    logic [1:0]  x_ok;
    logic [1:0]  y_ok;
    logic [1:0]  zone_d;
    logic [1:0]  zone_q;
    logic [1:0]  at_wall;
    logic [1:0]  at_wall_q;
    logic [1:0]  miss_d;
    logic [1:0]  miss_q;

    assign x13      = {1'b0, x_pos};
    assign y13      = {1'b0, y_pos};
    assign pad_y[0] = paddle_l_y;
    assign pad_y[1] = paddle_r_y;

    assign x_ok[0]    = (x13 <= L_EDGE);
    assign x_ok[1]    = ((x13 + RADIUS) >= R_EDGE);
    assign at_wall[0] = (x_pos == WALL_L);
    assign at_wall[1] = ((x13 + RADIUS) == WALL_R);

    // The vertical test is identical for both paddles.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_side
            logic [12:0] top13;
            assign top13      = {1'b0, pad_y[gi]};
            assign y_ok[gi]   = ((y13 + RADIUS) >= top13) && (y13 <= (top13 + Y_SPAN));
            assign zone_d[gi] = x_ok[gi] && y_ok[gi];
            // Rising edge of the wall condition only; no repeat while parked.
            assign miss_d[gi] = at_wall[gi] && !at_wall_q[gi];
        end
    endgenerate

    always_ff @(posedge pclk) begin
        if (reset) begin
            zone_q    <= 2'b00;
            // History starts "at wall" so a ball parked at a wall during
            // reset does not produce a spurious miss.
            at_wall_q <= 2'b11;
            miss_q    <= 2'b00;
        end else begin
            zone_q    <= zone_d;
            at_wall_q <= at_wall;
            miss_q    <= miss_d;
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2: hit / lockout FSM
    // -------------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [11:0]       x_hit_q, x_hit_d;
    logic [11:0]       x_prev_q;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic              collision_det_q, collision_det_d;
    logic [1:0]        hit_q, hit_d;
    logic              release_hit;
    logic              x_moved;

    // The mover has reacted, or it never did and the hold timed out.
    assign release_hit = (x_pos != x_hit_q) || (hold_cnt_q == HOLD_LAST);
    assign x_moved     = (x_pos != x_prev_q);

    // State register (plus the registered datapath/outputs it owns)
    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q         <= IDLE;
            x_hit_q         <= '0;
            x_prev_q        <= '0;
            hold_cnt_q      <= '0;
            lock_cnt_q      <= '0;
            collision_det_q <= 1'b0;
            hit_q           <= 2'b00;
        end else begin
            state_q         <= state_d;
            x_hit_q         <= x_hit_d;
            x_prev_q        <= x_pos;
            hold_cnt_q      <= hold_cnt_d;
            lock_cnt_q      <= lock_cnt_d;
            collision_det_q <= collision_det_d;
            hit_q           <= hit_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (zone_q[0] || zone_q[1]) begin
                    state_d = HIT;
                end
            end
            HIT: begin
                if (release_hit) begin
                    state_d = LOCKOUT;
                end
            end
            LOCKOUT: begin
                if (lock_cnt_q == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath logic (values registered by the state register)
    always_comb begin
        collision_det_d = 1'b0;
        hit_d           = 2'b00;
        x_hit_d         = x_hit_q;
        hold_cnt_d      = hold_cnt_q;
        lock_cnt_d      = lock_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (zone_q[0] || zone_q[1]) begin
                    collision_det_d = 1'b1;
                    x_hit_d         = x_pos;
                    hold_cnt_d      = '0;
                    // Left wins when both zones are true.
                    hit_d           = zone_q[0] ? 2'b01 : 2'b10;
                end
            end
            HIT: begin
                if (release_hit) begin
                    lock_cnt_d = LOCK_START;
                end else begin
                    collision_det_d = 1'b1;
                    hold_cnt_d      = hold_cnt_q + HOLD_W'(1);
                end
            end
            LOCKOUT: begin
                if ((lock_cnt_q != '0) && x_moved) begin
                    lock_cnt_d = lock_cnt_q - LOCK_W'(1);
                end
            end
            default: begin
                collision_det_d = 1'b0;
            end
        endcase
    end

    assign collision_det = collision_det_q;
    assign hit_left      = hit_q[0];
    assign hit_right     = hit_q[1];
    assign miss_left     = miss_q[0];
    assign miss_right    = miss_q[1];

endmodule

// File: tb/tb_ball_collision_det.sv
// -----------------------------------------------------------------------------
// Testbench for ball_collision_det. Two instances share the stimulus:
//   u_dut  - default parameters (main functional checks)
//   u_dut2 - HOLD_MAX=16 for the hold timeout, and overlapping paddle x
//            positions (both zones true at x=500) for the left-priority check.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_ball_collision_det;

    logic        pclk = 1'b0;
    logic        reset;
    logic [11:0] x_pos;
    logic [11:0] y_pos;
    logic [11:0] paddle_l_y;
    logic [11:0] paddle_r_y;

    logic cdet1, hl1, hr1, ml1, mr1;
    logic cdet2, hl2, hr2, ml2, mr2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 pclk = ~pclk;

    ball_collision_det u_dut (
        .pclk          (pclk),
        .reset         (reset),
        .x_pos         (x_pos),
        .y_pos         (y_pos),
        .paddle_l_y    (paddle_l_y),
        .paddle_r_y    (paddle_r_y),
        .collision_det (cdet1),
        .hit_left      (hl1),
        .hit_right     (hr1),
        .miss_left     (ml1),
        .miss_right    (mr1)
    );

    ball_collision_det #(
        .HOLD_MAX   (16),
        .PADDLE_L_X (500),
        .PADDLE_R_X (500)
    ) u_dut2 (
        .pclk          (pclk),
        .reset         (reset),
        .x_pos         (x_pos),
        .y_pos         (y_pos),
        .paddle_l_y    (paddle_l_y),
        .paddle_r_y    (paddle_r_y),
        .collision_det (cdet2),
        .hit_left      (hl2),
        .hit_right     (hr2),
        .miss_left     (ml2),
        .miss_right    (mr2)
    );

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Reset for 3 cycles with whatever inputs the caller has set up.
    task automatic apply_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0] outs;
        x_pos = 12'd40; y_pos = 12'd300; paddle_l_y = 12'd250; paddle_r_y = 12'd800;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            outs = {cdet1, hl1, hr1, ml1, mr1};
            n_checks++;
            if (outs !== 5'b0) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: got %b expected 00000", i, outs);
            end
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (cdet1 !== 1'b0) begin
            n_fail++;
            $display("FAIL hit_latency_1: collision_det got %b expected 0", cdet1);
        end
        tick();
        n_checks++;
        if ({cdet1, hl1, hr1} !== 3'b110) begin
            n_fail++;
            $display("FAIL hit_after_reset: {cdet,hl,hr} got %b expected 110", {cdet1, hl1, hr1});
        end
        tick();
        n_checks++;
        if ({cdet1, hl1, hr1} !== 3'b100) begin
            n_fail++;
            $display("FAIL hit_pulse_width: {cdet,hl,hr} got %b expected 100", {cdet1, hl1, hr1});
        end
    endtask

    task automatic test_hold_lockout();
        int bad = 0;
        // Continues from test_reset: DUT is in HIT with x=40.
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (cdet1 !== 1'b1) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL hold_1000: cycles low got %0d expected 0", bad);
        end
        x_pos = 12'd41;
        tick();
        n_checks++;
        if (cdet1 !== 1'b0) begin
            n_fail++;
            $display("FAIL release_on_move: collision_det got %b expected 0", cdet1);
        end
        // Four x changes while locked out; zone is true whenever x=40.
        for (int i = 0; i < 4; i++) begin
            x_pos = (i % 2 == 0) ? 12'd40 : 12'd41;
            tick();
            n_checks++;
            if ({cdet1, hl1} !== 2'b00) begin
                n_fail++;
                $display("FAIL lockout_toggle %0d: {cdet,hl} got %b expected 00", i, {cdet1, hl1});
            end
        end
        x_pos = 12'd40;
        tick();
        n_checks++;
        if (cdet1 !== 1'b0) begin
            n_fail++;
            $display("FAIL lockout_exit: collision_det got %b expected 0", cdet1);
        end
        tick();
        n_checks++;
        if ({cdet1, hl1} !== 2'b11) begin
            n_fail++;
            $display("FAIL rehit: {cdet,hl} got %b expected 11", {cdet1, hl1});
        end
    endtask

    task automatic test_y_boundaries();
        int   ys  [4] = '{240, 239, 360, 361};
        logic exp [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            x_pos = 12'd40; paddle_l_y = 12'd250; paddle_r_y = 12'd800;
            y_pos = 12'(ys[i]);
            apply_reset();
            tick();
            tick();
            n_checks++;
            if ({cdet1, hl1} !== {exp[i], exp[i]}) begin
                n_fail++;
                $display("FAIL y_boundary y=%0d: {cdet,hl} got %b expected %b%b",
                         ys[i], {cdet1, hl1}, exp[i], exp[i]);
            end
        end
    endtask

    task automatic test_right_and_priority();
        x_pos = 12'd983; y_pos = 12'd500; paddle_l_y = 12'd800; paddle_r_y = 12'd450;
        apply_reset();
        tick();
        tick();
        n_checks++;
        if ({cdet1, hl1, hr1} !== 3'b101) begin
            n_fail++;
            $display("FAIL right_hit: {cdet,hl,hr} got %b expected 101", {cdet1, hl1, hr1});
        end
        tick();
        n_checks++;
        if (hr1 !== 1'b0) begin
            n_fail++;
            $display("FAIL right_pulse_width: hit_right got %b expected 0", hr1);
        end
        // Overlapping paddles on u_dut2: both zones true at x=500.
        x_pos = 12'd500; y_pos = 12'd300; paddle_l_y = 12'd250; paddle_r_y = 12'd250;
        apply_reset();
        tick();
        tick();
        n_checks++;
        if ({cdet2, hl2, hr2} !== 3'b110) begin
            n_fail++;
            $display("FAIL left_priority: {cdet,hl,hr} got %b expected 110", {cdet2, hl2, hr2});
        end
    endtask

    task automatic test_miss();
        int pulses   = 0;
        int pulse_x  = -1;
        int cdet_hi  = 0;
        int pulse_cnt;
        // Ball parked at the left wall through reset must not pulse.
        x_pos = 12'd10; y_pos = 12'd300; paddle_l_y = 12'd600; paddle_r_y = 12'd600;
        apply_reset();
        tick();
        tick();
        n_checks++;
        if (ml1 !== 1'b0) begin
            n_fail++;
            $display("FAIL miss_at_reset: miss_left got %b expected 0", ml1);
        end
        x_pos = 12'd45;
        tick();
        for (int xv = 44; xv >= 10; xv--) begin
            x_pos = 12'(xv);
            tick();
            if (ml1 === 1'b1) begin
                pulses++;
                pulse_x = xv;
            end
            if (cdet1 !== 1'b0) cdet_hi++;
        end
        n_checks++;
        if (pulses !== 1 || pulse_x !== 10) begin
            n_fail++;
            $display("FAIL miss_sweep: pulses %0d at x=%0d expected 1 at x=10", pulses, pulse_x);
        end
        n_checks++;
        if (cdet_hi !== 0) begin
            n_fail++;
            $display("FAIL miss_no_collision: cycles high got %0d expected 0", cdet_hi);
        end
        pulse_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (ml1 !== 1'b0) pulse_cnt++;
        end
        n_checks++;
        if (pulse_cnt !== 0) begin
            n_fail++;
            $display("FAIL miss_no_repeat: pulses got %0d expected 0", pulse_cnt);
        end
        x_pos = 12'd11;
        tick();
        n_checks++;
        if (ml1 !== 1'b0) begin
            n_fail++;
            $display("FAIL miss_leave: miss_left got %b expected 0", ml1);
        end
        x_pos = 12'd10;
        tick();
        n_checks++;
        if (ml1 !== 1'b1) begin
            n_fail++;
            $display("FAIL miss_return: miss_left got %b expected 1", ml1);
        end
        x_pos = 12'd1013;
        tick();
        n_checks++;
        if ({mr1, ml1} !== 2'b10) begin
            n_fail++;
            $display("FAIL miss_right: {mr,ml} got %b expected 10", {mr1, ml1});
        end
        tick();
        n_checks++;
        if (mr1 !== 1'b0) begin
            n_fail++;
            $display("FAIL miss_right_width: miss_right got %b expected 0", mr1);
        end
    endtask

    task automatic test_timeout();
        int high = 0;
        int bad  = 0;
        x_pos = 12'd40; y_pos = 12'd300; paddle_l_y = 12'd250; paddle_r_y = 12'd800;
        apply_reset();
        tick();
        tick();
        if (cdet2 === 1'b1) high = 1;
        for (int i = 0; i < 40 && cdet2 === 1'b1; i++) begin
            tick();
            if (cdet2 === 1'b1) high++;
        end
        n_checks++;
        if (high !== 16) begin
            n_fail++;
            $display("FAIL hold_timeout: cycles high got %0d expected 16", high);
        end
        // x frozen in zone: FSM must sit in lockout, no re-hit.
        for (int i = 0; i < 20; i++) begin
            tick();
            if ({cdet2, hl2} !== 2'b00) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL lockout_wait: bad cycles got %0d expected 0", bad);
        end
    endtask

    task automatic test_reset_abort();
        x_pos = 12'd40; y_pos = 12'd300; paddle_l_y = 12'd250; paddle_r_y = 12'd800;
        apply_reset();
        tick();
        tick();
        reset = 1'b1;
        tick();
        n_checks++;
        if ({cdet1, hl1, cdet2, hl2} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_abort: {cdet1,hl1,cdet2,hl2} got %b expected 0000",
                     {cdet1, hl1, cdet2, hl2});
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (cdet1 !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle_1: collision_det got %b expected 0", cdet1);
        end
        tick();
        n_checks++;
        if ({cdet1, hl1} !== 2'b11) begin
            n_fail++;
            $display("FAIL abort_idle_rehit: {cdet,hl} got %b expected 11", {cdet1, hl1});
        end
    endtask

    initial begin
        reset      = 1'b1;
        x_pos      = 12'd40;
        y_pos      = 12'd300;
        paddle_l_y = 12'd250;
        paddle_r_y = 12'd800;
        test_reset();
        test_hold_lockout();
        test_y_boundaries();
        test_right_and_priority();
        test_miss();
        test_timeout();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
